// File: rtl/bus_xfer_pkg.sv
// Shared types for the bus transfer sequencer: opcodes, FSM states and the
// default data width.
package bus_xfer_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Command handshake plus the tristate bus side of the transfer sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
// the master holds cmd_* stable until then, cmd_ready never depends on cmd_valid.
interface bus_xfer_ctrl_if #(
  parameter int W    = bus_xfer_pkg::W_DEF,
  parameter int NREG = 4
);
  localparam int IW = $clog2(NREG);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_src;
  logic [IW-1:0] cmd_dst;
  logic [W-1:0]  ext_in;
  logic [W-1:0]  bus_i;
  logic          bus_c;
  logic [W-1:0]  bus_z;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, ext_in, bus_z,
    input  cmd_ready, bus_i, bus_c
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, ext_in, bus_z,
    output cmd_ready, bus_i, bus_c
  );

endinterface

// File: rtl/bus_regfile.sv
// NREG x W register bank: one synchronous write port, a source read port
// and a debug read port, both combinational.
module bus_regfile #(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [W-1:0]            wdata,
  input  logic [$clog2(NREG)-1:0] raddr,
  output logic [W-1:0]            rdata,
  input  logic [$clog2(NREG)-1:0] rd_idx,
  output logic [W-1:0]            rd_data
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata   = regs[raddr];
  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Upstream sequencer for the shared tristate bus: accepts MOV/LOAD/STORE
// commands, drives the bus for SETTLE cycles, then samples it. Optional
// completion counter enabled by BUS_XFER_COUNT_EN.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int NREG   = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  bus_xfer_ctrl_if.slave          bus,
  output logic [W-1:0]            ext_out,
  output logic                    done,
  output logic                    err,
  input  logic [$clog2(NREG)-1:0] rd_idx,
  output logic [W-1:0]            rd_data,
  output state_t                  dbg_state
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [7:0]              xfer_cnt
`endif
);

  localparam int IW = $clog2(NREG);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  state_t        state, state_nx;
  op_t           op_q;
  op_t           op_in;
  logic [IW-1:0] dst_q;
  logic [W-1:0]  bus_i_q;
  logic [W-1:0]  src_data;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          we;

  assign op_in     = op_t'(bus.cmd_op);
  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign dbg_state = state;
  assign bus.bus_i = bus_i_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Reserved ops skip DRIVE so the bus is never enabled for them.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = (op_in == OP_RSVD) ? S_LATCH : S_DRIVE;
      S_DRIVE: if (cnt == '0) state_nx = S_LATCH;
      S_LATCH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
    bus.bus_c     = (state == S_DRIVE) || ((state == S_LATCH) && (op_q != OP_RSVD));
    done          = (state == S_LATCH);
    err           = (state == S_LATCH) && (op_q == OP_RSVD);
    we            = (state == S_LATCH) && ((op_q == OP_MOV) || (op_q == OP_LOAD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MOV;
      dst_q   <= '0;
      bus_i_q <= '0;
      cnt     <= '0;
      ext_out <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        op_q  <= op_in;
        dst_q <= bus.cmd_dst;
        cnt   <= CNT_LOAD;
        if (op_in == OP_LOAD)      bus_i_q <= bus.ext_in;
        else if (op_in != OP_RSVD) bus_i_q <= src_data;
      end else if (state == S_DRIVE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == S_LATCH && op_q == OP_STORE) ext_out <= bus.bus_z;
    end
  end

`ifdef BUS_XFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)       xfer_cnt <= '0;
    else if (done) xfer_cnt <= xfer_cnt + 8'd1;
  end
`endif

  bus_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (dst_q),
    .wdata   (bus.bus_z),
    .raddr   (bus.cmd_src),
    .rdata   (src_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed table, randomized commands against a
// transaction-level model, mid-command reset and a SETTLE=3 latency instance.
module tb_bus_xfer_ctrl;
  import bus_xfer_pkg::*;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.W(4), .NREG(4)) a ();
  bus_xfer_ctrl_if #(.W(4), .NREG(4)) b ();

  logic [3:0] other_a, other_b;
  logic [3:0] ext_out_a, ext_out_b, rd_data_a, rd_data_b;
  logic [1:0] rd_idx_a, rd_idx_b;
  logic       done_a, done_b, err_a, err_b;
  state_t     state_a, state_b;
`ifdef BUS_XFER_COUNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  // Other bus drivers: random value whenever the sequencer is not driving.
  always @(negedge clk) begin
    other_a = 4'($urandom);
    other_b = 4'($urandom);
  end
  assign a.bus_z = a.bus_c ? a.bus_i : other_a;
  assign b.bus_z = b.bus_c ? b.bus_i : other_b;

  bus_xfer_ctrl #(.W(4), .NREG(4), .SETTLE(S1)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave), .ext_out(ext_out_a), .done(done_a),
    .err(err_a), .rd_idx(rd_idx_a), .rd_data(rd_data_a), .dbg_state(state_a)
`ifdef BUS_XFER_COUNT_EN
    , .xfer_cnt(cnt_a)
`endif
  );

  bus_xfer_ctrl #(.W(4), .NREG(4), .SETTLE(S3)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave), .ext_out(ext_out_b), .done(done_b),
    .err(err_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b), .dbg_state(state_b)
`ifdef BUS_XFER_COUNT_EN
    , .xfer_cnt(cnt_b)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] m_reg [4];
  logic [3:0] m_ext;
  int         m_cnt;

  typedef struct {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] ext;
    logic [3:0] exp_val;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
    m_ext = 4'h0;
    m_cnt = 0;
  endtask

  task automatic compare_state();
    for (int i = 0; i < 4; i++) begin
      rd_idx_a = 2'(i);
      #1;
      check($sformatf("reg%0d", i), int'(rd_data_a), int'(m_reg[i]));
    end
    check("ext_out", int'(ext_out_a), int'(m_ext));
`ifdef BUS_XFER_COUNT_EN
    check("xfer_cnt", int'(cnt_a), m_cnt);
`endif
  endtask

  // Offers one command to dut_a at the current negedge and follows it to completion.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] ext, input int exp_lat, input logic exp_err);
    logic [3:0] word;
    int lat, bc, n;
    logic bad, seen_err;
    word = (op == 2'b01) ? ext : m_reg[src];
    a.cmd_valid = 1'b1; a.cmd_op = op; a.cmd_src = src; a.cmd_dst = dst; a.ext_in = ext;
    n = 0;
    while (!a.cmd_ready && n < 8) begin @(negedge clk); n++; end
    check("accept_ready", int'(a.cmd_ready), 1);
    check("idle_bus_c", int'(a.bus_c), 0);
    @(negedge clk);
    lat = 0; bc = 0; bad = 1'b0; seen_err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (a.bus_c) begin
        bc++;
        if (a.bus_i !== word) bad = 1'b1;
      end
      if (done_a) begin
        lat = k;
        seen_err = err_a;
        break;
      end
      // Busy-time garbage on the command port must be ignored.
      a.cmd_valid = 1'($urandom_range(0, 1));
      a.cmd_op = 2'($urandom); a.cmd_src = 2'($urandom);
      a.cmd_dst = 2'($urandom); a.ext_in = 4'($urandom);
      @(negedge clk);
    end
    a.cmd_valid = 1'b0;
    check("done_latency", lat, exp_lat);
    check("err_pulse", int'(seen_err), int'(exp_err));
    check("bus_c_cycles", bc, (op == 2'b11) ? 0 : exp_lat);
    check("bus_i_word", int'(bad), 0);
    case (op)
      2'b00: m_reg[dst] = m_reg[src];
      2'b01: m_reg[dst] = ext;
      2'b10: m_ext = m_reg[src];
      default: ;
    endcase
    m_cnt = (m_cnt + 1) % 256;
    @(negedge clk);
    check("turnaround_bus_c", int'(a.bus_c), 0);
    check("turnaround_ready", int'(a.cmd_ready), 1);
    check("done_one_cycle", int'(done_a), 0);
    compare_state();
  endtask

  task automatic run_b(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] ext, output int lat);
    b.cmd_valid = 1'b1; b.cmd_op = op; b.cmd_src = src; b.cmd_dst = dst; b.ext_in = ext;
    check("b_ready", int'(b.cmd_ready), 1);
    @(negedge clk);
    b.cmd_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (done_b) begin
        lat = k;
        check("b_err", int'(err_b), 0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [1:0] op, src, dst;

    tbl[0] = '{2'd1, 2'd0, 2'd2, 4'hA, 4'hA, S1 + 1, 1'b0};
    tbl[1] = '{2'd1, 2'd0, 2'd1, 4'h5, 4'h5, S1 + 1, 1'b0};
    tbl[2] = '{2'd0, 2'd1, 2'd3, 4'h0, 4'h5, S1 + 1, 1'b0};
    tbl[3] = '{2'd2, 2'd3, 2'd0, 4'h0, 4'h5, S1 + 1, 1'b0};
    tbl[4] = '{2'd3, 2'd0, 2'd2, 4'hF, 4'hA, 1,      1'b1};
    tbl[5] = '{2'd0, 2'd2, 2'd2, 4'h0, 4'hA, S1 + 1, 1'b0};
    tbl[6] = '{2'd1, 2'd0, 2'd0, 4'h3, 4'h3, S1 + 1, 1'b0};
    tbl[7] = '{2'd2, 2'd2, 2'd1, 4'h0, 4'hA, S1 + 1, 1'b0};

    a.cmd_valid = 1'b0; a.cmd_op = 2'd0; a.cmd_src = 2'd0; a.cmd_dst = 2'd0; a.ext_in = 4'h0;
    b.cmd_valid = 1'b0; b.cmd_op = 2'd0; b.cmd_src = 2'd0; b.cmd_dst = 2'd0; b.ext_in = 4'h0;
    rd_idx_a = 2'd0; rd_idx_b = 2'd0;
    model_reset();

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state_a), int'(S_IDLE));
    check("rst_bus_c", int'(a.bus_c), 0);
    check("rst_bus_i", int'(a.bus_i), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_err", int'(err_a), 0);
    compare_state();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(a.cmd_ready), 1);
    check("post_rst_state", int'(state_a), int'(S_IDLE));

    // Directed table
    for (int t = 0; t < 8; t++) begin
      run_cmd(tbl[t].op, tbl[t].src, tbl[t].dst, tbl[t].ext, tbl[t].exp_lat, tbl[t].exp_err);
      @(negedge clk);
      if (tbl[t].op == 2'd2) begin
        check("tbl_ext", int'(ext_out_a), int'(tbl[t].exp_val));
      end else begin
        rd_idx_a = tbl[t].dst;
        #1;
        check("tbl_reg", int'(rd_data_a), int'(tbl[t].exp_val));
      end
    end

    // SETTLE=3 instance: done in the 4th cycle after the accept cycle
    @(negedge clk);
    run_b(2'd1, 2'd0, 2'd1, 4'h6, lat);
    check("b_load_latency", lat, S3 + 1);
    run_b(2'd2, 2'd1, 2'd0, 4'h0, lat);
    check("b_store_latency", lat, S3 + 1);
    check("b_ext_out", int'(ext_out_b), 6);
    check("b_bus_c_idle", int'(b.bus_c), 0);
    check("b_state_idle", int'(state_b), int'(S_IDLE));
    rd_idx_b = 2'd1;
    #1;
    check("b_reg1", int'(rd_data_b), 6);
`ifdef BUS_XFER_COUNT_EN
    check("b_xfer_cnt", int'(cnt_b), 2);
`endif

    // Random traffic against the model
    @(negedge clk);
    for (int r = 0; r < 60; r++) begin
      op = 2'($urandom_range(0, 3));
      src = 2'($urandom); dst = 2'($urandom);
      run_cmd(op, src, dst, 4'($urandom), (op == 2'd3) ? 1 : S1 + 1, op == 2'd3);
    end

    // Reset while a LOAD r0=F is driving the bus
    a.cmd_valid = 1'b1; a.cmd_op = 2'd1; a.cmd_src = 2'd0; a.cmd_dst = 2'd0; a.ext_in = 4'hF;
    @(negedge clk);
    a.cmd_valid = 1'b0;
    check("mid_rst_driving", int'(a.bus_c), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_done", int'(done_a), 0);
    check("mid_rst_bus_c", int'(a.bus_c), 0);
    check("mid_rst_ready", int'(a.cmd_ready), 1);
    check("mid_rst_state", int'(state_a), int'(S_IDLE));
    compare_state();
    @(negedge clk);
    check("mid_rst_no_done", int'(done_a), 0);

    // 256 completions: 4 loads then 252 moves
    for (int i = 0; i < 4; i++)
      run_cmd(2'd1, 2'd0, 2'(i), 4'($urandom), S1 + 1, 1'b0);
    for (int i = 0; i < 252; i++)
      run_cmd(2'd0, 2'($urandom), 2'($urandom), 4'h0, S1 + 1, 1'b0);
`ifdef BUS_XFER_COUNT_EN
    check("xfer_cnt_wrap", int'(cnt_a), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
